axil_arbiter2: RTL and testbench
================================

// Module: axil_arbiter2
//
// PURPOSE
// - Two-master to one-slave AXI-lite arbiter.
// - Shares a single downstream AXI-lite slave (e.g. a register file or the
//   empty error-responder shell) between two upstream masters.
// - Read and write directions are arbitrated independently, round-robin.
// - At most one transaction per direction is outstanding.
//
// PARAMETERS
// C_AXI_ADDR_WIDTH  4   address width, passed through unchanged
// C_AXI_DATA_WIDTH  32  data width; strobe width = C_AXI_DATA_WIDTH/8
// OPT_LOWPOWER      0   1: forced-zero M_AXI addr/data/strb when the matching VALID is low
//
// PORTS  (S_ = upstream, packed [1:0] per master, master i in bits i; M_ = downstream)
// S_AXI_ACLK   in  1  clock
// i_reset      in  1  synchronous, active-high reset
// S_AXI_AWVALID, S_AXI_WVALID, S_AXI_ARVALID, S_AXI_BREADY, S_AXI_RREADY   in   2  per-master
// S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID   out  2  per-master
// S_AXI_AWADDR, S_AXI_ARADDR   in   2*AW  per-master addresses
// S_AXI_WDATA  in  2*DW  per-master write data;  S_AXI_WSTRB  in  2*DW/8  strobes
// S_AXI_BRESP  out  2*2   per-master write response;  S_AXI_RRESP  out  2*2
// S_AXI_RDATA  out  2*DW  per-master read data
// M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY  out  1
// M_AXI_AWREADY, M_AXI_WREADY, M_AXI_ARREADY, M_AXI_BVALID, M_AXI_RVALID  in   1
// M_AXI_AWADDR/ARADDR out AW; M_AXI_WDATA out DW; M_AXI_WSTRB out DW/8
// M_AXI_BRESP in 2; M_AXI_RRESP in 2; M_AXI_RDATA in DW
//
// BEHAVIOUR
// - Write FSM states: WIDLE -> WADDR -> WRESP -> WIDLE.
// - Read FSM states: RIDLE -> RADDR -> RRESP -> RIDLE.
// - Clock S_AXI_ACLK; reset i_reset is synchronous, active-high.
// - Reset:
//   - Both FSMs go to IDLE.
//   - Write and read last-grant pointers go to 1, so master 0 wins the first tie.
//   - All S_/M_ VALID and READY outputs are 0.
//   - Reset mid-transaction abandons the transaction; the downstream slave shares i_reset.
// - WIDLE:
//   - Request = S_AXI_AWVALID[i]. If any request, register grant wg and go to WADDR next cycle.
//   - If both request, grant !last_wgrant; then last_wgrant <= wg.
//   - One cycle of arbitration latency; no S_ or M_ handshake occurs in IDLE.
// - WADDR:
//   - M_AXI_AWVALID = S_AXI_AWVALID[wg] && !aw_done; M_AXI_WVALID = S_AXI_WVALID[wg] && !w_done.
//   - S_AXI_AWREADY[wg] = M_AXI_AWREADY && !aw_done; S_AXI_WREADY[wg] likewise.
//   - Addr, data and strb are muxed combinationally from master wg.
//   - aw_done/w_done set on their M_ handshakes. AW and W may complete in either order or together.
//   - Go to WRESP once both are done (including same cycle); clear both flags.
// - WRESP:
//   - S_AXI_BVALID[wg] = M_AXI_BVALID; M_AXI_BREADY = S_AXI_BREADY[wg]; BRESP passed through.
//   - Go to WIDLE on the B handshake.
// - Read path mirrors the write path: RIDLE arbitrates on S_AXI_ARVALID (grant rg, own pointer).
//   - RADDR forwards AR combinationally; go to RRESP on the M_ AR handshake.
//   - RRESP forwards R; go to RIDLE on the R handshake.
// - Non-granted master: all its READY/VALID outputs are 0; its RDATA/RRESP/BRESP are 0.
// - Read and write are fully independent and may serve different masters in the same cycle.
// - Throughput: at most 1 transaction per 3 cycles per direction (IDLE, ADDR, RESP).
// - Fairness: a master that is continuously requesting waits at most one transaction of the other master.
// - Upstream VALID dropping before its handshake is illegal AXI; behaviour is unspecified.
//
// TESTING
// - Both masters raise AW+W at cycle 0 after reset.
//   -> master 0 granted at cycle 1; master 1 after master 0's B handshake.
//   -> each master receives exactly one BVALID.
// - With the empty error shell downstream, master 1 issues a read.
//   -> S_AXI_RVALID[1]=1, RRESP[1]=2'b11, RDATA[1]=0; S_AXI_RVALID[0] stays 0.
// - Master 0 presents AW 3 cycles before W.
//   -> AWREADY[0] pulses once; WREADY[0] pulses once later; one M_ B per transaction.
// - Master 0 writes while master 1 reads concurrently.
//   -> both complete with no cross-talk: BVALID only in bit 0, RVALID only in bit 1.
// - Both masters hold ARVALID for 6 reads.
//   -> grant order 0,1,0,1,0,1; M_AXI_RREADY low while BREADY/RREADY upstream is held 0.
// - Assert i_reset during WRESP.
//   -> next cycle all VALID/READY outputs are 0, FSM in WIDLE, master 0 wins the next tie.

Source files
------------

// File: rtl/axil_arbiter2_if.sv
// Bus bundle for the two-master AXI-lite arbiter: packed per-master upstream
// signals (master i in slice i) plus the single downstream port.
interface axil_arbiter2_if #(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32
);
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  logic [1:0]      S_AXI_AWVALID, S_AXI_AWREADY;
  logic [2*AW-1:0] S_AXI_AWADDR;
  logic [1:0]      S_AXI_WVALID, S_AXI_WREADY;
  logic [2*DW-1:0] S_AXI_WDATA;
  logic [2*SW-1:0] S_AXI_WSTRB;
  logic [1:0]      S_AXI_BVALID, S_AXI_BREADY;
  logic [3:0]      S_AXI_BRESP;
  logic [1:0]      S_AXI_ARVALID, S_AXI_ARREADY;
  logic [2*AW-1:0] S_AXI_ARADDR;
  logic [1:0]      S_AXI_RVALID, S_AXI_RREADY;
  logic [2*DW-1:0] S_AXI_RDATA;
  logic [3:0]      S_AXI_RRESP;

  logic          M_AXI_AWVALID, M_AXI_AWREADY;
  logic [AW-1:0] M_AXI_AWADDR;
  logic          M_AXI_WVALID, M_AXI_WREADY;
  logic [DW-1:0] M_AXI_WDATA;
  logic [SW-1:0] M_AXI_WSTRB;
  logic          M_AXI_BVALID, M_AXI_BREADY;
  logic [1:0]    M_AXI_BRESP;
  logic          M_AXI_ARVALID, M_AXI_ARREADY;
  logic [AW-1:0] M_AXI_ARADDR;
  logic          M_AXI_RVALID, M_AXI_RREADY;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;

  // Arbiter view: accepts upstream requests, drives the downstream port.
  modport slave (
    input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
    output S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );

  // Environment view: upstream masters and downstream slave.
  modport master (
    output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
    input  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );
endinterface

// File: rtl/axil_arbiter2.sv
// Two-master to one-slave AXI-lite arbiter; read and write directions are
// arbitrated independently, round-robin, one transaction outstanding each.
module axil_arbiter2 #(
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter bit OPT_LOWPOWER     = 1'b0
) (
  input logic           S_AXI_ACLK,
  input logic           i_reset,
  axil_arbiter2_if.slave bus
);
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int SW = C_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {WIDLE, WADDR, WRESP} wstate_e;
  typedef enum logic [1:0] {RIDLE, RADDR, RRESP} rstate_e;

  wstate_e wstate;
  rstate_e rstate;
  logic    wg, last_wg, aw_done, w_done;
  logic    rg, last_rg;
  logic    wg_next, rg_next;
  logic    awv, wv, arv;
  logic    aw_hs, w_hs, b_hs, ar_hs, r_hs;

  always_comb begin
    wg_next = (&bus.S_AXI_AWVALID) ? !last_wg : bus.S_AXI_AWVALID[1];
    rg_next = (&bus.S_AXI_ARVALID) ? !last_rg : bus.S_AXI_ARVALID[1];
  end

  // Write direction
  always_ff @(posedge S_AXI_ACLK) begin
    if (i_reset) begin
      wstate  <= WIDLE;
      wg      <= 1'b0;
      last_wg <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (wstate)
        WIDLE: if (|bus.S_AXI_AWVALID) begin
          wg      <= wg_next;
          last_wg <= wg_next;
          wstate  <= WADDR;
        end
        WADDR: begin
          // AW and W may finish in either order; leave once both have.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            wstate  <= WRESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WRESP: if (b_hs) wstate <= WIDLE;
        default: wstate <= WIDLE;
      endcase
    end
  end

  always_comb begin
    bus.S_AXI_AWREADY = '0;
    bus.S_AXI_WREADY  = '0;
    bus.S_AXI_BVALID  = '0;
    bus.S_AXI_BRESP   = '0;
    awv = (wstate == WADDR) && bus.S_AXI_AWVALID[wg] && !aw_done;
    wv  = (wstate == WADDR) && bus.S_AXI_WVALID[wg]  && !w_done;
    bus.M_AXI_AWVALID = awv;
    bus.M_AXI_WVALID  = wv;
    bus.M_AXI_BREADY  = (wstate == WRESP) && bus.S_AXI_BREADY[wg];
    if (wstate == WADDR) begin
      bus.S_AXI_AWREADY[wg] = bus.M_AXI_AWREADY && !aw_done;
      bus.S_AXI_WREADY[wg]  = bus.M_AXI_WREADY  && !w_done;
    end
    if (wstate == WRESP) begin
      bus.S_AXI_BVALID[wg] = bus.M_AXI_BVALID;
      if (wg) bus.S_AXI_BRESP[3:2] = bus.M_AXI_BRESP;
      else    bus.S_AXI_BRESP[1:0] = bus.M_AXI_BRESP;
    end
    bus.M_AXI_AWADDR = wg ? bus.S_AXI_AWADDR[2*AW-1:AW] : bus.S_AXI_AWADDR[AW-1:0];
    bus.M_AXI_WDATA  = wg ? bus.S_AXI_WDATA[2*DW-1:DW]  : bus.S_AXI_WDATA[DW-1:0];
    bus.M_AXI_WSTRB  = wg ? bus.S_AXI_WSTRB[2*SW-1:SW]  : bus.S_AXI_WSTRB[SW-1:0];
    if (OPT_LOWPOWER && !awv) bus.M_AXI_AWADDR = '0;
    if (OPT_LOWPOWER && !wv) begin
      bus.M_AXI_WDATA = '0;
      bus.M_AXI_WSTRB = '0;
    end
  end

  always_comb begin
    aw_hs = awv && bus.M_AXI_AWREADY;
    w_hs  = wv  && bus.M_AXI_WREADY;
    b_hs  = bus.M_AXI_BVALID && bus.M_AXI_BREADY;
  end

  // Read direction
  always_ff @(posedge S_AXI_ACLK) begin
    if (i_reset) begin
      rstate  <= RIDLE;
      rg      <= 1'b0;
      last_rg <= 1'b1;
    end else begin
      case (rstate)
        RIDLE: if (|bus.S_AXI_ARVALID) begin
          rg      <= rg_next;
          last_rg <= rg_next;
          rstate  <= RADDR;
        end
        RADDR: if (ar_hs) rstate <= RRESP;
        RRESP: if (r_hs)  rstate <= RIDLE;
        default: rstate <= RIDLE;
      endcase
    end
  end

  always_comb begin
    bus.S_AXI_ARREADY = '0;
    bus.S_AXI_RVALID  = '0;
    bus.S_AXI_RDATA   = '0;
    bus.S_AXI_RRESP   = '0;
    arv = (rstate == RADDR) && bus.S_AXI_ARVALID[rg];
    bus.M_AXI_ARVALID = arv;
    bus.M_AXI_RREADY  = (rstate == RRESP) && bus.S_AXI_RREADY[rg];
    if (rstate == RADDR) bus.S_AXI_ARREADY[rg] = bus.M_AXI_ARREADY;
    if (rstate == RRESP) begin
      bus.S_AXI_RVALID[rg] = bus.M_AXI_RVALID;
      if (rg) begin
        bus.S_AXI_RDATA[2*DW-1:DW] = bus.M_AXI_RDATA;
        bus.S_AXI_RRESP[3:2]       = bus.M_AXI_RRESP;
      end else begin
        bus.S_AXI_RDATA[DW-1:0] = bus.M_AXI_RDATA;
        bus.S_AXI_RRESP[1:0]    = bus.M_AXI_RRESP;
      end
    end
    bus.M_AXI_ARADDR = rg ? bus.S_AXI_ARADDR[2*AW-1:AW] : bus.S_AXI_ARADDR[AW-1:0];
    if (OPT_LOWPOWER && !arv) bus.M_AXI_ARADDR = '0;
  end

  always_comb begin
    ar_hs = arv && bus.M_AXI_ARREADY;
    r_hs  = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
  end

endmodule

// File: tb/tb_axil_arbiter2.sv
// Bench for axil_arbiter2: two upstream master threads, a downstream memory
// slave, and a monitor scoreboarding responses against a reference memory.
module tb_axil_arbiter2;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int MAXW = 200;

  typedef logic [33:0] rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_arbiter2_if #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW)) bus ();

  axil_arbiter2 #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .OPT_LOWPOWER(1'b1)) dut (
    .S_AXI_ACLK(clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  // Upstream master drive state, one slot per master
  logic          av[2]  = '{1'b0, 1'b0};
  logic          wv[2]  = '{1'b0, 1'b0};
  logic          arv[2] = '{1'b0, 1'b0};
  logic          br[2]  = '{1'b0, 1'b0};
  logic          rr[2]  = '{1'b0, 1'b0};
  logic [AW-1:0] awa[2] = '{'0, '0};
  logic [AW-1:0] ara[2] = '{'0, '0};
  logic [DW-1:0] wd[2]  = '{'0, '0};
  logic [3:0]    ws[2]  = '{'0, '0};

  assign bus.S_AXI_AWVALID = {av[1], av[0]};
  assign bus.S_AXI_WVALID  = {wv[1], wv[0]};
  assign bus.S_AXI_ARVALID = {arv[1], arv[0]};
  assign bus.S_AXI_BREADY  = {br[1], br[0]};
  assign bus.S_AXI_RREADY  = {rr[1], rr[0]};
  assign bus.S_AXI_AWADDR  = {awa[1], awa[0]};
  assign bus.S_AXI_ARADDR  = {ara[1], ara[0]};
  assign bus.S_AXI_WDATA   = {wd[1], wd[0]};
  assign bus.S_AXI_WSTRB   = {ws[1], ws[0]};

  // Reference model and scoreboard
  logic [DW-1:0] ref_mem[16];
  logic [1:0]    bq[2][$];
  rexp_t         rq[2][$];
  int            wgq[$];
  int            rgq[$];
  int            checks = 0, passes = 0;
  int            aw_iss[2] = '{0, 0}, w_iss[2] = '{0, 0};
  int            aw_seen[2] = '{0, 0}, w_seen[2] = '{0, 0}, b_seen[2] = '{0, 0};
  bit            slave_err = 1'b0, hold_b = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    $display("FAIL %s: no handshake within %0d cycles", nm, MAXW);
  endtask

  function automatic logic [14:0] all_hs_outs();
    return {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
            bus.S_AXI_RVALID, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
            bus.M_AXI_BREADY, bus.M_AXI_RREADY};
  endfunction

  // Master m writes its own half of the address space (address bit 3 = m).
  task automatic mwrite(input int m, input logic [2:0] off, input logic [31:0] d,
                        input logic [3:0] s, input int gaw, input int gw, input bit want_b);
    logic [3:0] a;
    int cyc;
    bit awp, wp, awh, wh, bh;
    a = {m[0], off};
    cyc = 0; awp = 1'b1; wp = 1'b1;
    aw_iss[m]++;
    w_iss[m]++;
    if (!slave_err)
      for (int unsigned b = 0; b < 4; b++) if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    if (want_b) bq[m].push_back(slave_err ? 2'b11 : 2'b00);
    awa[m] = a; wd[m] = d; ws[m] = s;
    if (gaw == 0) av[m] = 1'b1;
    if (gw == 0)  wv[m] = 1'b1;
    while (awp || wp) begin
      @(negedge clk);
      awh = av[m] && bus.S_AXI_AWREADY[m];
      wh  = wv[m] && bus.S_AXI_WREADY[m];
      @(posedge clk); #1;
      cyc++;
      if (awh) begin av[m] = 1'b0; awp = 1'b0; end
      if (wh)  begin wv[m] = 1'b0; wp = 1'b0; end
      if (awp && cyc == gaw) av[m] = 1'b1;
      if (wp && cyc == gw)   wv[m] = 1'b1;
      if (cyc > MAXW) begin
        timeout_fail($sformatf("aw_w_wait%0d", m));
        av[m] = 1'b0; wv[m] = 1'b0;
        return;
      end
    end
    if (!want_b) return;
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 br[m] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      bh = bus.S_AXI_BVALID[m];
      @(posedge clk); #1;
      cyc++;
    end while (!bh && cyc <= MAXW);
    if (!bh) timeout_fail($sformatf("b_wait%0d", m));
    br[m] = 1'b0;
  endtask

  task automatic mread(input int m, input logic [2:0] off);
    logic [3:0] a;
    int cyc;
    bit arh, rh;
    a = {m[0], off};
    rq[m].push_back(slave_err ? {2'b11, 32'h0} : {2'b00, ref_mem[a]});
    ara[m] = a;
    arv[m] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      arh = bus.S_AXI_ARREADY[m];
      @(posedge clk); #1;
      cyc++;
    end while (!arh && cyc <= MAXW);
    arv[m] = 1'b0;
    if (!arh) begin
      timeout_fail($sformatf("ar_wait%0d", m));
      return;
    end
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1 rr[m] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      rh = bus.S_AXI_RVALID[m];
      @(posedge clk); #1;
      cyc++;
    end while (!rh && cyc <= MAXW);
    if (!rh) timeout_fail($sformatf("r_wait%0d", m));
    rr[m] = 1'b0;
  endtask

  // Downstream slave: 16-word memory with random ready/valid timing
  logic [DW-1:0] smem[16];
  initial begin
    bit rs, awh, wh, bh, arh, rh, got_aw, got_w, b_pend, r_pend;
    logic [3:0] sa, sra;
    logic [DW-1:0] sd;
    logic [3:0] ss;
    logic [1:0] bresp_v;
    got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
    sa = '0; sra = '0; sd = '0; ss = '0; bresp_v = '0;
    for (int i = 0; i < 16; i++) begin smem[i] = '0; ref_mem[i] = '0; end
    bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
    bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = '0;
    bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = '0; bus.M_AXI_RRESP = '0;
    forever begin
      @(negedge clk);
      rs  = rst;
      awh = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
      wh  = bus.M_AXI_WVALID  && bus.M_AXI_WREADY;
      bh  = bus.M_AXI_BVALID  && bus.M_AXI_BREADY;
      arh = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
      rh  = bus.M_AXI_RVALID  && bus.M_AXI_RREADY;
      if (awh) sa = bus.M_AXI_AWADDR;
      if (wh) begin sd = bus.M_AXI_WDATA; ss = bus.M_AXI_WSTRB; end
      if (arh) sra = bus.M_AXI_ARADDR;
      @(posedge clk); #1;
      if (rs) begin
        got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_ARREADY = 0;
        bus.M_AXI_BVALID = 0; bus.M_AXI_RVALID = 0;
        continue;
      end
      if (awh) got_aw = 1;
      if (wh)  got_w  = 1;
      if (bh)  bus.M_AXI_BVALID = 0;
      if (rh)  bus.M_AXI_RVALID = 0;
      if (arh) r_pend = 1;
      if (got_aw && got_w) begin
        if (!slave_err)
          for (int unsigned b = 0; b < 4; b++) if (ss[b]) smem[sa][8*b +: 8] = sd[8*b +: 8];
        bresp_v = slave_err ? 2'b11 : 2'b00;
        got_aw = 0; got_w = 0; b_pend = 1;
      end
      if (b_pend && !bus.M_AXI_BVALID && !hold_b && $urandom_range(0, 1) == 1) begin
        bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = bresp_v; b_pend = 0;
      end
      if (r_pend && !bus.M_AXI_RVALID && $urandom_range(0, 1) == 1) begin
        bus.M_AXI_RVALID = 1;
        bus.M_AXI_RDATA  = slave_err ? '0 : smem[sra];
        bus.M_AXI_RRESP  = slave_err ? 2'b11 : 2'b00;
        r_pend = 0;
      end
      bus.M_AXI_AWREADY = !got_aw && ($urandom_range(0, 1) == 1);
      bus.M_AXI_WREADY  = !got_w  && ($urandom_range(0, 1) == 1);
      bus.M_AXI_ARREADY = !r_pend && !bus.M_AXI_RVALID && ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response
  initial begin
    forever begin
      @(negedge clk);
      if (rst) continue;
      for (int m = 0; m < 2; m++) begin
        int o;
        o = 1 - m;
        if (bus.S_AXI_AWVALID[m] && bus.S_AXI_AWREADY[m]) aw_seen[m]++;
        if (bus.S_AXI_WVALID[m]  && bus.S_AXI_WREADY[m])  w_seen[m]++;
        if (bq[m].size() == 0) chk($sformatf("bvalid_unexp%0d", m), bus.S_AXI_BVALID[m], 0);
        else if (bus.S_AXI_BVALID[m] && bus.S_AXI_BREADY[m]) begin
          b_seen[m]++;
          chk($sformatf("bresp%0d", m), bus.S_AXI_BRESP[2*m +: 2], bq[m].pop_front());
        end
        if (rq[m].size() == 0) chk($sformatf("rvalid_unexp%0d", m), bus.S_AXI_RVALID[m], 0);
        else if (bus.S_AXI_RVALID[m] && bus.S_AXI_RREADY[m])
          chk($sformatf("rdata%0d", m), {bus.S_AXI_RRESP[2*m +: 2], bus.S_AXI_RDATA[DW*m +: DW]},
              rq[m].pop_front());
        if (bus.S_AXI_RVALID[m])
          chk($sformatf("r_xtalk%0d", o), {bus.S_AXI_RVALID[o], bus.S_AXI_RRESP[2*o +: 2],
              bus.S_AXI_RDATA[DW*o +: DW]}, 0);
        if (bus.S_AXI_BVALID[m])
          chk($sformatf("b_xtalk%0d", o), {bus.S_AXI_BVALID[o], bus.S_AXI_BRESP[2*o +: 2]}, 0);
      end
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY && wgq.size() > 0)
        chk("wgrant", bus.M_AXI_AWADDR[3], wgq.pop_front());
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY && rgq.size() > 0)
        chk("rgrant", bus.M_AXI_ARADDR[3], rgq.pop_front());
      if (bus.M_AXI_AWVALID && (av[0] ^ av[1]))
        chk("aw_route", bus.M_AXI_AWADDR, av[1] ? awa[1] : awa[0]);
      if (bus.M_AXI_WVALID && (wv[0] ^ wv[1]))
        chk("w_route", {bus.M_AXI_WSTRB, bus.M_AXI_WDATA}, wv[1] ? {ws[1], wd[1]} : {ws[0], wd[0]});
      if (!bus.M_AXI_AWVALID && (av[0] || av[1])) chk("lp_awaddr", bus.M_AXI_AWADDR, 0);
      if (!bus.M_AXI_ARVALID && (arv[0] || arv[1])) chk("lp_araddr", bus.M_AXI_ARADDR, 0);
      if (bus.M_AXI_RVALID) chk("rready_gate", bus.M_AXI_RREADY && !(rr[0] || rr[1]), 0);
      if (bus.M_AXI_BVALID) chk("bready_gate", bus.M_AXI_BREADY && !(br[0] || br[1]), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d before abort", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, aw0, w0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", all_hs_outs(), 0);

    // Simultaneous writes: master 0 wins the first tie
    wgq.push_back(0); wgq.push_back(1);
    fork
      mwrite(0, 3'd1, 32'hA5A5_0001, 4'hF, 0, 0, 1'b1);
      mwrite(1, 3'd2, 32'h5A5A_0002, 4'hF, 0, 0, 1'b1);
    join
    @(negedge clk);
    chk("one_b_m0", b_seen[0], 1);
    chk("one_b_m1", b_seen[1], 1);

    // Error responder downstream, read from master 1
    slave_err = 1'b1;
    mread(1, 3'd5);
    slave_err = 1'b0;

    // AW leads W by 3 cycles
    aw0 = aw_seen[0]; w0 = w_seen[0]; b0 = b_seen[0];
    mwrite(0, 3'd3, 32'hDEAD_BEEF, 4'b0101, 0, 3, 1'b1);
    @(negedge clk);
    chk("gap_aw_once", aw_seen[0] - aw0, 1);
    chk("gap_w_once", w_seen[0] - w0, 1);
    chk("gap_b_once", b_seen[0] - b0, 1);

    // Concurrent write on master 0 and read on master 1
    fork
      mwrite(0, 3'd4, 32'h1234_5678, 4'hF, 1, 0, 1'b1);
      mread(1, 3'd2);
    join

    // Both masters hold ARVALID over six reads
    for (int i = 0; i < 3; i++) begin rgq.push_back(0); rgq.push_back(1); end
    fork
      for (int i = 0; i < 3; i++) mread(0, 3'(i + 1));
      for (int i = 0; i < 3; i++) mread(1, 3'(i + 2));
    join
    chk("rgrant_all_seen", rgq.size(), 0);

    // Reset while the write waits for its response
    hold_b = 1'b1;
    mwrite(0, 3'd6, 32'h0BAD_F00D, 4'hF, 0, 0, 1'b0);
    @(negedge clk);
    chk("b_held", bus.S_AXI_BVALID, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    hold_b = 1'b0;
    @(negedge clk);
    chk("reset_mid_outs", all_hs_outs(), 0);
    wgq.push_back(0); wgq.push_back(1);
    fork
      mwrite(0, 3'd7, 32'hCAFE_0007, 4'hF, 0, 0, 1'b1);
      mwrite(1, 3'd7, 32'hCAFE_1007, 4'hF, 0, 0, 1'b1);
    join
    chk("wgrant_all_seen", wgq.size(), 0);

    // Random traffic, then read back every word
    fork
      for (int i = 0; i < 25; i++) begin
        if ($urandom_range(0, 1) == 1)
          mwrite(0, 3'($urandom), $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
        else mread(0, 3'($urandom));
      end
      for (int i = 0; i < 25; i++) begin
        if ($urandom_range(0, 1) == 1)
          mwrite(1, 3'($urandom), $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
        else mread(1, 3'($urandom));
      end
    join
    fork
      for (int i = 0; i < 8; i++) mread(0, 3'(i));
      for (int i = 0; i < 8; i++) mread(1, 3'(i));
    join

    repeat (4) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("aw_count%0d", m), aw_seen[m], aw_iss[m]);
      chk($sformatf("w_count%0d", m), w_seen[m], w_iss[m]);
      chk($sformatf("b_left%0d", m), bq[m].size(), 0);
      chk($sformatf("r_left%0d", m), rq[m].size(), 0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
